// File: rtl/ram2_stream_reader.sv
// rtl/ram2_stream_reader.sv - read-side master that sweeps the dataset RAM and streams 16-bit fields
//
// Purpose:
//   On a start pulse, reads rows 0..num_points-1 of the dataset RAM. Each row is
//   unpacked into num_features feature fields followed by the y field, and the
//   fields are sent one per beat over a valid/ready stream.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   start               begin a sweep (honoured only while idle)
//   num_points          rows to read, clamped to DEPTH, latched at start
//   num_features        features per row, clamped to MAX_FEATURES, latched at start
//   ram_addr/oe/we      RAM control (we is tied low, the RAM is only read)
//   ram_data            RAM read data
//   out_data/feat/point field value, field index in row, row index
//   out_last            high on the y beat of a row
//   out_valid/out_ready stream handshake
//   busy                high whenever a sweep is in progress
//   done                one-cycle pulse when the sweep completes

module ram2_stream_reader #(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
    parameter int DEPTH        = 100,
    parameter int FEAT_BITS    = 4,
    parameter int WAIT_CYCLES  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] num_points,
    input  logic [FEAT_BITS-1:0]  num_features,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_oe,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic [LENGTH-1:0]     out_data,
    output logic [FEAT_BITS-1:0]  out_feat,
    output logic [ADDR_WIDTH-1:0] out_point,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [ADDR_WIDTH-1:0] np_q,    np_d;
    logic [FEAT_BITS-1:0]  nf_q,    nf_d;
    logic [FEAT_BITS-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] row_q,   row_d;

    logic [ADDR_WIDTH-1:0] np_clamped;
    logic [FEAT_BITS-1:0]  nf_clamped;
    logic [LENGTH-1:0]     fields [MAX_FEATURES+1];
    logic [LENGTH-1:0]     field_sel;
    logic                  in_stream;
    logic                  y_beat;
    logic                  last_row;
    logic                  wait_over;

    // Configuration clamping. Compared at 32 bits so the check stays meaningful
    // whatever the port widths are relative to the limits.
    always_comb begin
        if (32'(num_points) > 32'(DEPTH)) begin
            np_clamped = ADDR_WIDTH'(DEPTH);
        end else begin
            np_clamped = num_points;
        end
        if (32'(num_features) > 32'(MAX_FEATURES)) begin
            nf_clamped = FEAT_BITS'(MAX_FEATURES);
        end else begin
            nf_clamped = num_features;
        end
    end

    // Row register viewed as an array of fields; slot MAX_FEATURES is always y,
    // regardless of how many features the sweep uses.
    always_comb begin
        for (int k = 0; k <= MAX_FEATURES; k++) begin
            fields[k] = row_q[LENGTH*k +: LENGTH];
        end
    end

    assign in_stream = (state_q == S_STREAM);
    assign y_beat    = (idx_q == nf_q);
    assign last_row  = (addr_q == (np_q - ADDR_WIDTH'(1)));
    assign wait_over = (cnt_q == CNT_W'(WAIT_CYCLES - 1));
    assign field_sel = y_beat ? fields[MAX_FEATURES] : fields[idx_q];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        np_d    = np_q;
        nf_d    = nf_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        row_d   = row_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    np_d   = np_clamped;
                    nf_d   = nf_clamped;
                    addr_d = '0;
                    idx_d  = '0;
                    cnt_d  = '0;
                    // An empty sweep finishes without touching the RAM.
                    state_d = (np_clamped == '0) ? S_DONE : S_WAIT;
                end
            end

            S_WAIT: begin
                // Address has been stable for WAIT_CYCLES edges on the capture edge.
                if (wait_over) begin
                    row_d   = ram_data;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_STREAM: begin
                if (out_ready) begin
                    if (y_beat) begin
                        idx_d = '0;
                        if (last_row) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            cnt_d   = '0;
                            state_d = S_WAIT;
                        end
                    end else begin
                        idx_d = idx_q + FEAT_BITS'(1);
                    end
                end
            end

            S_DONE: begin
                // Park the address so the idle bus looks the same as after reset.
                addr_d  = '0;
                idx_d   = '0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            np_q    <= '0;
            nf_q    <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            np_q    <= np_d;
            nf_q    <= nf_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

    // Outputs are decoded from registered state only; stream fields are zeroed
    // outside STREAM so idle/reset outputs are all zero.
    assign ram_addr  = addr_q;
    assign ram_oe    = (state_q == S_WAIT) || in_stream;
    assign ram_we    = 1'b0;
    assign out_valid = in_stream;
    assign out_data  = in_stream ? field_sel : '0;
    assign out_feat  = in_stream ? idx_q : '0;
    assign out_last  = in_stream && y_beat;
    assign out_point = addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ram2_stream_reader.sv
// tb/tb_ram2_stream_reader.sv - self-checking bench for ram2_stream_reader

module tb_ram2_stream_reader;

    localparam int WAIT = 2;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  feat;
        logic [11:0] point;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [11:0]  num_points;
    logic [3:0]   num_features;
    logic [11:0]  ram_addr;
    logic         ram_oe;
    logic         ram_we;
    wire  [255:0] ram_data;
    logic [15:0]  out_data;
    logic [3:0]   out_feat;
    logic [11:0]  out_point;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;

    logic [255:0] mem [0:127];

    int checks   = 0;
    int failures = 0;

    initial forever #5 clk = ~clk;

    assign ram_data = (ram_oe && ram_addr < 12'd100) ? mem[ram_addr[6:0]] : {256{1'bz}};

    ram2_stream_reader #(
        .ADDR_WIDTH(12), .MAX_FEATURES(15), .LENGTH(16), .DATA_WIDTH(256),
        .DEPTH(100), .FEAT_BITS(4), .WAIT_CYCLES(WAIT)
    ) dut (
        .CLK(clk), .RST(rst), .start(start), .num_points(num_points),
        .num_features(num_features), .ram_addr(ram_addr), .ram_oe(ram_oe),
        .ram_we(ram_we), .ram_data(ram_data), .out_data(out_data),
        .out_feat(out_feat), .out_point(out_point), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_ram_addr"},  ram_addr,  0);
        chk({tag, "_ram_oe"},    ram_oe,    0);
        chk({tag, "_ram_we"},    ram_we,    0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_out_feat"},  out_feat,  0);
        chk({tag, "_out_point"}, out_point, 0);
        chk({tag, "_out_last"},  out_last,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
    endtask

    task automatic fill_pattern();
        for (int r = 0; r < 128; r++)
            for (int k = 0; k < 16; k++)
                mem[r][16*k +: 16] = {4'h0, 4'(k), 4'h0, 4'(r)};
    endtask

    task automatic fill_random();
        for (int r = 0; r < 128; r++)
            for (int w = 0; w < 8; w++)
                mem[r][32*w +: 32] = $urandom;
    endtask

    // One sweep: the expected beat list is built from the row/field rules, then the
    // stream is consumed with random (or forced-low) ready while every valid beat is
    // compared against the head of that list.
    task automatic sweep(input int np, input int nf, input int pct, input bit bp,
                         input int rst_beat, input int busy_beat);
        beat_t exp_q[$];
        beat_t e;
        int np_c, nf_c, cyc, beats, first_valid, done_cyc, last_acc, stall_left;
        bit bp_done, finished, busy_pulse, busy_done;
        np_c = (np > 100) ? 100 : np;
        nf_c = (nf > 15) ? 15 : nf;
        for (int r = 0; r < np_c; r++) begin
            for (int k = 0; k <= nf_c; k++) begin
                e.data  = (k == nf_c) ? mem[r][16*15 +: 16] : mem[r][16*k +: 16];
                e.feat  = 4'(k);
                e.point = 12'(r);
                e.last  = (k == nf_c);
                exp_q.push_back(e);
            end
        end
        num_points   = 12'(np);
        num_features = 4'(nf);
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start        = 1'b0;
        num_points   = 12'($urandom);
        num_features = 4'($urandom);
        cyc = 0; beats = 0; first_valid = -1; done_cyc = -1; stall_left = 0;
        last_acc = (np_c == 0) ? -1 : -100;
        bp_done = 0; finished = 0; busy_pulse = 0; busy_done = 0;
        while (!finished && cyc < 20000) begin
            if (busy_pulse) begin
                start = 1'b0;
                busy_pulse = 0;
            end
            chk("ram_we_low", ram_we, 0);
            if (ram_oe) chk("addr_in_range", ram_addr < 12'd100, 1);
            if (np_c == 0) begin
                chk("np0_oe", ram_oe, 0);
                chk("np0_valid", out_valid, 0);
            end
            if (out_valid && first_valid < 0) begin
                first_valid = cyc;
                chk("first_valid_cycle", cyc, WAIT);
            end
            if (rst_beat >= 0 && out_valid && beats == rst_beat) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_idle_zero("mid_reset");
                rst = 1'b0;
                return;
            end
            if (done) begin
                chk("done_cycle", cyc, last_acc + 1);
                chk("done_all_beats", exp_q.size(), 0);
                chk("busy_in_done", busy, 1);
                done_cyc = cyc;
            end else if (done_cyc >= 0) begin
                chk("busy_fall", busy, 0);
                chk("done_single", done, 0);
                finished = 1;
            end
            if (bp && !bp_done && out_valid && beats == 2) begin
                stall_left = 5;
                bp_done = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < pct);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk("out_data",  out_data,  e.data);
                    chk("out_feat",  out_feat,  e.feat);
                    chk("out_point", out_point, e.point);
                    chk("out_last",  out_last,  e.last);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                        last_acc = cyc;
                    end
                end
            end
            if (busy_beat >= 0 && !busy_done && out_valid && beats == busy_beat) begin
                start = 1'b1;
                num_points = 12'd5;
                busy_pulse = 1;
                busy_done = 1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!finished) chk("sweep_timeout", finished, 1);
        chk("beats_left", exp_q.size(), 0);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_points = '0; num_features = '0; out_ready = 1'b0;
        fill_pattern();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // basic sweep with the 16'h0k0r pattern
        sweep(2, 3, 100, 1'b0, -1, -1);
        // backpressure: 5-cycle ready drop mid-row
        fill_random();
        sweep(3, 5, 100, 1'b1, -1, -1);
        // empty sweep
        sweep(0, 3, 100, 1'b0, -1, -1);
        // num_points clamped to 100 with random ready
        sweep(200, 4, 70, 1'b0, -1, -1);
        // y-only rows
        sweep(4, 0, 80, 1'b0, -1, -1);
        // full feature count
        sweep(3, 15, 60, 1'b0, -1, -1);
        // reset during row 1 beat 2, then a fresh sweep from row 0
        sweep(3, 3, 100, 1'b0, 6, -1);
        sweep(2, 3, 100, 1'b0, -1, -1);
        // start pulsed while streaming
        sweep(3, 2, 100, 1'b0, -1, 3);
        // random sweeps
        for (int i = 0; i < 4; i++) begin
            fill_random();
            sweep(int'($urandom_range(6, 1)), int'($urandom_range(15, 0)),
                  int'($urandom_range(100, 40)), 1'b0, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram2_stream_reader.md
# ram2_stream_reader

Read-side master for the dataset RAM. On a start pulse it sweeps the RAM from address 0 and unpacks each stored data point into 16-bit fields, sending them out one per beat over a valid/ready stream. The stream carries `num_features` feature fields followed by the y field. It sits between the dataset RAM (`oe`/`we`/`addr`/`data` port) and the regression datapath, replacing ad-hoc testbench reads.

## Interface
- `ADDR_WIDTH`, 12: RAM address width.
- `MAX_FEATURES`, 15: maximum features per data point.
- `LENGTH`, 16: bits per field.
- `DATA_WIDTH`, `LENGTH*(MAX_FEATURES+1)` (256): RAM word width.
- `DEPTH`, 100: RAM rows.
- `FEAT_BITS`, 4: width of feature-count and index ports.
- `WAIT_CYCLES`, 2: cycles the address is held before capture; minimum 1.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `num_points`  in  ADDR_WIDTH  rows to read; sampled at start.
- `num_features`  in  FEAT_BITS  features per row; sampled at start.
- `ram_addr`  out  ADDR_WIDTH  RAM address.
- `ram_oe`  out  1  RAM output enable.
- `ram_we`  out  1  RAM write enable; constant 0.
- `ram_data`  in  DATA_WIDTH  RAM read data; the bus is tri-stated by the RAM when not driven.
- `out_data`  out  LENGTH  current field.
- `out_feat`  out  FEAT_BITS  field index within the row (0..num_features).
- `out_point`  out  ADDR_WIDTH  row index.
- `out_last`  out  1  high on the y beat.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  consumer accepts the beat.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse when the sweep completes.

## Operation
- **Reset values:** all outputs are 0, and the state is IDLE.
- **Field layout:**
  - Feature k occupies `data[LENGTH*k +: LENGTH]`, for k = 0 .. num_features-1.
  - y occupies `data[LENGTH*MAX_FEATURES +: LENGTH]`.
- **Configuration at start:**
  - `num_features` above MAX_FEATURES is clamped to MAX_FEATURES.
  - `num_points` above DEPTH is clamped to DEPTH.
  - Both are latched; later input changes are ignored.
- **States:**
  - IDLE: `ram_oe`=0. On `start` with `num_points`≠0 → WAIT, with `ram_addr`=0, `ram_oe`=1 and the wait counter at 0. On `start` with `num_points`=0 → DONE, with no RAM access.
  - WAIT: address held, `ram_oe`=1. The counter increments each cycle. On the edge where the counter equals WAIT_CYCLES-1, `ram_data` is latched into the row register → STREAM, with `out_valid`=1 and field index 0.
  - STREAM: `out_data` is the field selected by the index; the y field is used when index = num_features. `out_valid` holds and `out_data` stays stable until `out_valid & out_ready`. On each accept the index increments.
    - On accepting the y beat with more rows remaining: `ram_addr`+1 → WAIT, `out_valid`=0.
    - On accepting the y beat of the last row → DONE.
  - DONE: `done`=1 and `ram_oe`=0 for one cycle → IDLE.
- `start` is ignored while busy; it does not restart or queue a sweep.
- RST asserted in any state forces the reset values at the next edge. Any partially streamed row is discarded.
- `ram_we` is never driven high. The RAM is therefore never written and its bus stays in read direction.

## Timing
- Take `start` as sampled at edge N:
  - `ram_addr`/`ram_oe` are valid after edge N.
  - The row is captured at edge N+WAIT_CYCLES, and `out_valid` rises after that edge.
- Row-to-row gap: after the y beat is accepted at edge M, `out_valid` stays low until edge M+WAIT_CYCLES captures the next row.
- Throughput with `out_ready` held high: `num_features`+1 beats per row, plus a WAIT_CYCLES-cycle gap per row.
- `done` is asserted the cycle after the final accept. `busy` falls one cycle after that.
- `num_features`=0: each row is a single y beat with `out_last`=1 and `out_feat`=0.

## Test plan
- **Basic sweep:** preload rows 0–1 with field k = 16'h0k0r. `num_points`=2, `num_features`=3, `out_ready`=1.
  - Expect beats 0x0000, 0x0100, 0x0200, y.
  - Expect `out_last` on beat 4 of each row, `out_valid` first high 2 cycles after `start`, and a single `done` pulse.
- **Backpressure:** drop `out_ready` for 5 cycles mid-row. Expect `out_data`/`out_feat` stable, with no beat lost or duplicated.
- **num_points=0:** `start` produces a `done` pulse the next cycle, `ram_oe` never 1, `out_valid` never 1.
- **Clamping:** `num_points`=200 reads exactly rows 0–99 and `ram_addr` never exceeds 99. `num_features`=0 gives y-only beats.
- **Mid-sweep reset:** assert RST during row 1, beat 2. After the next edge expect all outputs 0 and IDLE. A fresh `start` then restreams from row 0.
- **start while busy:** pulse `start` during STREAM. Expect no effect on the sequence or on the `done` count.
